mc_control_unit: RTL

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit_pkg.sv | 74 +++++++
 rtl/mc_control_unit_alu_decoder.sv | 44 ++++
 rtl/mc_control_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mc_control_unit_pkg.sv
// Multi-cycle RV32I control: shared encodings.
// Used by the control FSM, its ALU decoder and the datapath.
package mc_control_unit_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        R_EXE,
        I_EXE,
        B_EXE,
        LU_EXE,
        AU_EXE,
        J_EXE,
        JL_EXE,
        S_EXE,
        S_MEM,
        L_EXE,
        L_MEM,
        L_WB
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_L     = 7'b0000011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [2:0] FUNCT3_SR = 3'b101;

    localparam logic [2:0] RFWD_ALU   = 3'd0;
    localparam logic [2:0] RFWD_MEM   = 3'd1;
    localparam logic [2:0] RFWD_IMM   = 3'd2;
    localparam logic [2:0] RFWD_AUIPC = 3'd3;
    localparam logic [2:0] RFWD_PC4   = 3'd4;

    // First execute state for an opcode; unknown opcodes go back to FETCH.
    function automatic state_t decode_target(input logic [6:0] op);
        state_t s;
        s = FETCH;
        unique case (1'b1)
            (op == OP_R):     s = R_EXE;
            (op == OP_I):     s = I_EXE;
            (op == OP_B):     s = B_EXE;
            (op == OP_LUI):   s = LU_EXE;
            (op == OP_AUIPC): s = AU_EXE;
            (op == OP_JAL):   s = J_EXE;
            (op == OP_JALR):  s = JL_EXE;
            (op == OP_S):     s = S_EXE;
            (op == OP_L):     s = L_EXE;
            default:          s = FETCH;
        endcase
        return s;
    endfunction

    function automatic logic is_known_op(input logic [6:0] op);
        return decode_target(op) != FETCH;
    endfunction

endpackage

// File: rtl/mc_control_unit_alu_decoder.sv
// ALU operation select for the multi-cycle control unit.
// Purely combinational; only R/I/B execute states use funct fields.
module mc_alu_decoder
    import mc_control_unit_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] aluControl
);

    logic is_alu_state;

    assign is_alu_state = (state == R_EXE)
                       || (state == I_EXE)
                       || (state == B_EXE);

    // Select the ALU op from funct fields in R/I/B execute, else ADD.
    always_comb begin
        aluControl = ALU_ADD;
        if (is_alu_state) begin
            unique case (1'b1)
                (opcode == OP_R): begin
                    aluControl = {funct7_5, funct3};
                end
                (opcode == OP_I): begin
                    if (funct3 == FUNCT3_SR) begin
                        aluControl = {funct7_5, funct3};
                    end else begin
                        aluControl = {1'b0, funct3};
                    end
                end
                (opcode == OP_B): begin
                    aluControl = {1'b0, funct3};
                end
                default: begin
                    aluControl = ALU_ADD;
                end
            endcase
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit: Moore FSM over the IR.
// Write strobes are forced low while reset is held.
module mc_control_unit
    import mc_control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
    output logic        irWe,
    output logic        pcEn,
    output logic        regFileWe,
    output logic [3:0]  aluControl,
    output logic        aluSrcMuxSel,
    output logic [2:0]  RFWDSrcMuxSel,
    output logic        branch,
    output logic        jump,
    output logic        jalr,
    output logic        dataWe
);

    state_t state;
    state_t state_next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [20:0] unused_instr_bits;

    assign opcode   = instrCode[6:0];
    assign funct3   = instrCode[14:12];
    assign funct7_5 = instrCode[30];

    assign unused_instr_bits = {
        instrCode[31],
        instrCode[29:15],
        instrCode[11:7]
    };

    mc_alu_decoder u_alu_dec (
        .state      (state),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .aluControl (aluControl)
    );

    // State register; reset returns to FETCH from any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; reset masks every enable.
    always_comb begin
        state_next    = state;
        irWe          = 1'b0;
        pcEn          = 1'b0;
        regFileWe     = 1'b0;
        aluSrcMuxSel  = 1'b0;
        RFWDSrcMuxSel = RFWD_ALU;
        branch        = 1'b0;
        jump          = 1'b0;
        jalr          = 1'b0;
        dataWe        = 1'b0;

        unique case (state)
            FETCH: begin
                state_next = DECODE;
                irWe       = 1'b1;
            end
            DECODE: begin
                state_next = decode_target(opcode);
                pcEn       = !is_known_op(opcode);
            end
            R_EXE: begin
                state_next = FETCH;
                pcEn       = 1'b1;
                regFileWe  = 1'b1;
            end
            I_EXE: begin
                state_next   = FETCH;
                pcEn         = 1'b1;
                regFileWe    = 1'b1;
                aluSrcMuxSel = 1'b1;
            end
            B_EXE: begin
                state_next = FETCH;
                pcEn       = 1'b1;
                branch     = 1'b1;
            end
            LU_EXE: begin
                state_next    = FETCH;
                pcEn          = 1'b1;
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = RFWD_IMM;
            end
            AU_EXE: begin
                state_next    = FETCH;
                pcEn          = 1'b1;
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = RFWD_AUIPC;
            end
            J_EXE: begin
                state_next    = FETCH;
                pcEn          = 1'b1;
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = RFWD_PC4;
                jump          = 1'b1;
            end
            JL_EXE: begin
                state_next    = FETCH;
                pcEn          = 1'b1;
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = RFWD_PC4;
                jump          = 1'b1;
                jalr          = 1'b1;
            end
            S_EXE: begin
                state_next   = S_MEM;
                aluSrcMuxSel = 1'b1;
            end
            S_MEM: begin
                state_next   = FETCH;
                aluSrcMuxSel = 1'b1;
                pcEn         = 1'b1;
                dataWe       = 1'b1;
            end
            L_EXE: begin
                state_next   = L_MEM;
                aluSrcMuxSel = 1'b1;
            end
            L_MEM: begin
                state_next   = L_WB;
                aluSrcMuxSel = 1'b1;
            end
            L_WB: begin
                state_next    = FETCH;
                aluSrcMuxSel  = 1'b1;
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = RFWD_MEM;
                pcEn          = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        if (reset) begin
            irWe      = 1'b0;
            pcEn      = 1'b0;
            regFileWe = 1'b0;
            dataWe    = 1'b0;
        end
    end

endmodule
